id_scoreboard: RTL and testbench

//   Register-hazard scheduler for the decode stage. Tracks in-flight GPR writes

---
 rtl/id_scoreboard.sv | 86 ++++++++
 tb/tb_id_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-GPR pending-write counters that gate decode issue on RAW/WAW-capacity hazards.
// Optional perf counters are enabled by defining ID_SCB_PERF_EN.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ds_valid,
  input  logic            ds_src1_used,
  input  logic [4:0]      ds_raddr1,
  input  logic            ds_src2_used,
  input  logic [4:0]      ds_raddr2,
  input  logic            ds_gr_we,
  input  logic [4:0]      ds_dest,
  input  logic            es_allowin,
  input  logic            ws_rf_we,
  input  logic [4:0]      ws_rf_waddr,
  input  logic            flush,
  output logic            ds_ready_go,
  output logic            issue_fire,
  output logic [NREG-1:0] busy_vec,
  output logic            err_underflow,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     issue_count
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic haz1, haz2, full, inc, dec;
  always_comb begin
    haz1 = ds_src1_used && ds_raddr1 != 5'd0 && cnt_q[ds_raddr1] != '0;
    haz2 = ds_src2_used && ds_raddr2 != 5'd0 && cnt_q[ds_raddr2] != '0;
    full = ds_gr_we && ds_dest != 5'd0 && cnt_q[ds_dest] == MAX &&
           !(ws_rf_we && ws_rf_waddr == ds_dest);
    ds_ready_go = !(haz1 || haz2 || full);
    issue_fire = ds_valid && ds_ready_go && es_allowin && !flush;
  end
  // r0 is never tracked, so its counter stays at zero
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc = issue_fire && ds_gr_we && ds_dest == 5'(r);
      dec = ws_rf_we && ws_rf_waddr == 5'(r);
      cnt_d[r] = cnt_q[r];
      if (flush) cnt_d[r] = '0;
      else if (inc && !dec) cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc && cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
      else if (dec && !inc) err_d = 1'b1;
    end
  end
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NREG; i++) busy_vec[i] = |cnt_q[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_underflow = err_q;
`ifdef ID_SCB_PERF_EN
  logic [31:0] stall_q, iss_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      iss_q <= '0;
    end else begin
      stall_q <= stall_q + {31'd0, ds_valid && !ds_ready_go};
      iss_q <= iss_q + {31'd0, issue_fire};
    end
  end
  assign stall_cycles = stall_q;
  assign issue_count = iss_q;
`else
  assign stall_cycles = 32'h0;
  assign issue_count = 32'h0;
`endif
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: randomized and directed checks of id_scoreboard against a counter-array model.
module tb_id_scoreboard;
  logic clk = 1'b0, reset = 1'b1;
  logic ds_valid, ds_src1_used, ds_src2_used, ds_gr_we, es_allowin, ws_rf_we, flush;
  logic [4:0] ds_raddr1, ds_raddr2, ds_dest, ws_rf_waddr;
  logic ds_ready_go, issue_fire, err_underflow;
  logic [31:0] busy_vec, stall_cycles, issue_count;
  int errors = 0, checks = 0;
  int m_cnt[32];
  bit m_err;
  int unsigned m_stall, m_iss;
  bit mf;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_src1_used(ds_src1_used),
    .ds_raddr1(ds_raddr1), .ds_src2_used(ds_src2_used), .ds_raddr2(ds_raddr2),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .es_allowin(es_allowin),
    .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .flush(flush),
    .ds_ready_go(ds_ready_go), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .err_underflow(err_underflow), .stall_cycles(stall_cycles), .issue_count(issue_count)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_ready();
    bit h1 = ds_src1_used && ds_raddr1 != 0 && m_cnt[ds_raddr1] > 0;
    bit h2 = ds_src2_used && ds_raddr2 != 0 && m_cnt[ds_raddr2] > 0;
    bit fl = ds_gr_we && ds_dest != 0 && m_cnt[ds_dest] == 3 && !(ws_rf_we && ws_rf_waddr == ds_dest);
    return !(h1 || h2 || fl);
  endfunction

  function automatic bit m_fire();
    return ds_valid && m_ready() && es_allowin && !flush;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int i = 0; i < 32; i++) b[i] = m_cnt[i] > 0;
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0;
      m_stall = 0;
      m_iss = 0;
    end else begin
      mf = m_fire();
      if (ds_valid && !m_ready()) m_stall++;
      if (mf) m_iss++;
      if (flush) foreach (m_cnt[i]) m_cnt[i] = 0;
      else begin
        if (ws_rf_we && ws_rf_waddr != 0 && !(mf && ds_gr_we && ds_dest == ws_rf_waddr)) begin
          if (m_cnt[ws_rf_waddr] == 0) m_err = 1;
          else m_cnt[ws_rf_waddr]--;
        end
        if (mf && ds_gr_we && ds_dest != 0 && !(ws_rf_we && ws_rf_waddr == ds_dest)) m_cnt[ds_dest]++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_go", ds_ready_go, m_ready());
      chk("issue_fire", issue_fire, m_fire());
      chk("busy_vec", busy_vec, m_busy());
      chk("err_underflow", err_underflow, m_err);
`ifdef ID_SCB_PERF_EN
      chk("stall_cycles", stall_cycles, m_stall);
      chk("issue_count", issue_count, m_iss);
`else
      chk("stall_cycles", stall_cycles, 0);
      chk("issue_count", issue_count, 0);
`endif
    end
  end

  task automatic idle();
    {ds_valid, ds_src1_used, ds_src2_used, ds_gr_we, ws_rf_we, flush} = '0;
    {ds_raddr1, ds_raddr2, ds_dest, ws_rf_waddr} = '0;
    es_allowin = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_to(input logic [4:0] d);
    idle();
    ds_valid = 1; ds_gr_we = 1; ds_dest = d;
  endtask

  initial begin
    idle();
    #2 chk("reset_busy", busy_vec, 0);
    chk("reset_err", err_underflow, 0);
    #10 reset = 0;
    tick();
    // RAW on r5: stall persists through the retire cycle
    issue_to(5);
    #1 chk("t1_fire", issue_fire, 1);
    tick();
    idle(); ds_valid = 1; ds_src1_used = 1; ds_raddr1 = 5;
    #1 chk("t1_busy5", busy_vec[5], 1);
    chk("t1_stall", ds_ready_go, 0);
    tick();
    ws_rf_we = 1; ws_rf_waddr = 5;
    #1 chk("t1_same_retire", ds_ready_go, 0);
    tick();
    ws_rf_we = 0;
    #1 chk("t1_go", ds_ready_go, 1);
    chk("t1_busy5_clr", busy_vec[5], 0);
    tick();
    // counter saturation on r7
    issue_to(7);
    repeat (3) tick();
    #1 chk("t2_full", ds_ready_go, 0);
    ws_rf_we = 1; ws_rf_waddr = 7;
    #1 chk("t2_retire_go", ds_ready_go, 1);
    chk("t2_fire", issue_fire, 1);
    tick();
    ws_rf_we = 0; ds_valid = 0;
    #1 chk("t2_still_full", ds_ready_go, 0);
    idle(); ws_rf_we = 1; ws_rf_waddr = 7;
    repeat (3) tick();
    idle();
    #1 chk("t2_drained", busy_vec, 0);
    // r0 ignored
    issue_to(0); ws_rf_we = 1; ws_rf_waddr = 0;
    tick();
    idle();
    #1 chk("t3_busy", busy_vec, 0);
    chk("t3_err", err_underflow, 0);
    // underflow on r9 is sticky
    ws_rf_we = 1; ws_rf_waddr = 9;
    tick();
    idle();
    repeat (2) tick();
    chk("t4_err", err_underflow, 1);
    chk("t4_busy9", busy_vec[9], 0);
    // flush with concurrent issue
    issue_to(3); tick();
    issue_to(4); tick();
    issue_to(6); flush = 1;
    #1 chk("t5_fire_flush", issue_fire, 0);
    chk("t5_busy_before", busy_vec, 32'h18);
    tick();
    idle();
    #1 chk("t5_busy_flushed", busy_vec, 0);
    // async reset mid-traffic
    issue_to(10); tick();
    #2 reset = 1;
    #1 chk("t5_rst_busy", busy_vec, 0);
    chk("t5_rst_err", err_underflow, 0);
    chk("t5_rst_stall", stall_cycles, 0);
    reset = 0;
    idle();
    tick();
    // perf: 4 stall cycles, 2 issues
    issue_to(12); tick();
    idle(); ds_valid = 1; ds_src1_used = 1; ds_raddr1 = 12;
    repeat (3) tick();
    ws_rf_we = 1; ws_rf_waddr = 12; tick();
    ws_rf_we = 0; tick();
    idle();
    #1;
`ifdef ID_SCB_PERF_EN
    chk("t6_stall", stall_cycles, 4);
    chk("t6_issue", issue_count, 2);
`else
    chk("t6_stall", stall_cycles, 0);
    chk("t6_issue", issue_count, 0);
`endif
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int w;
      ds_valid = $urandom_range(0, 3) != 0;
      ds_src1_used = $urandom_range(0, 1) == 1;
      ds_src2_used = $urandom_range(0, 1) == 1;
      ds_raddr1 = 5'($urandom_range(0, 7));
      ds_raddr2 = 5'($urandom_range(0, 7));
      ds_gr_we = $urandom_range(0, 3) != 0;
      ds_dest = 5'($urandom_range(0, 7));
      es_allowin = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 99) == 0;
      w = $urandom_range(0, 7);
      ws_rf_we = (m_cnt[w] > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 49) == 0;
      ws_rf_waddr = 5'(w);
      tick();
    end
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
